// File: rtl/wb_dram_pattern_tester.sv
// wb_dram_pattern_tester: Wishbone DRAM self-test master that writes a pattern, reads it back and reports errors.
module wb_dram_pattern_tester #(
  parameter int          DATA_WIDTH     = 256,
  parameter int          ADDR_WIDTH     = 25,
  parameter int          BASE_ADDR      = 0,
  parameter int          NUM_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_2345,
  parameter bit          STOP_ON_ERR    = 1'b0
) (
  input  logic                    user_clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    init_done,
  input  logic                    init_error,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [31:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_adr,
  output logic [DATA_WIDTH-1:0]   first_err_data
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_INIT, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_DONE} state_t;
  state_t state;
  logic [1:0] mode_r;
  logic [31:0] idx, lfsr, lfsr_next, tmo_cnt, err_next;
  logic [DATA_WIDTH-1:0] pattern;
  logic term, err_hit, last, stop, tmo_hit;
  function automatic logic [DATA_WIDTH-1:0] gen(input logic [1:0] m, input logic [31:0] i, input logic [31:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < DATA_WIDTH / 32; k++)
      r[k*32 +: 32] = m == 2'd0 ? 32'hA5A5_A5A5 : m == 2'd1 ? i : m == 2'd2 ? ~i : s ^ 32'(k);
    return r;
  endfunction
  assign wb_sel = '1;
  always_comb begin
    pattern = gen(mode_r, idx, lfsr);
    lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    term = wb_cyc & (wb_ack | wb_err);
    err_hit = term & (wb_err | (!wb_we & (wb_dat_r != pattern)));
    err_next = (err_hit & ~&err_count) ? err_count + 32'd1 : err_count;
    last = idx == 32'(NUM_WORDS - 1);
    stop = last | (STOP_ON_ERR & err_hit);
    tmo_hit = tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge user_clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mode_r <= '0;
      idx <= '0;
      lfsr <= LFSR_SEED;
      tmo_cnt <= '0;
      wb_adr <= '0;
      wb_dat_w <= '0;
      wb_cyc <= 1'b0;
      wb_stb <= 1'b0;
      wb_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      first_err_adr <= '0;
      first_err_data <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state <= S_WAIT_INIT;
          mode_r <= mode;
          idx <= '0;
          lfsr <= LFSR_SEED;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          fail <= 1'b0;
          timeout <= 1'b0;
          err_count <= '0;
          first_err_adr <= '0;
          first_err_data <= '0;
        end
        S_WAIT_INIT: if (init_error) begin
          state <= S_DONE;
          busy <= 1'b0;
          done <= 1'b1;
          fail <= 1'b1;
        end else if (init_done) state <= S_WR_REQ;
        S_WR_REQ, S_RD_REQ: begin
          wb_cyc <= 1'b1;
          wb_stb <= 1'b1;
          wb_we <= state == S_WR_REQ;
          wb_adr <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
          wb_dat_w <= state == S_WR_REQ ? pattern : '0;
          tmo_cnt <= '0;
          state <= state == S_WR_REQ ? S_WR_WAIT : S_RD_WAIT;
        end
        S_WR_WAIT, S_RD_WAIT: begin
          if (term | tmo_hit) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we <= 1'b0;
            wb_adr <= '0;
            wb_dat_w <= '0;
          end
          if (term) begin
            err_count <= err_next;
            idx <= last ? '0 : idx + 32'd1;
            if (err_hit && err_count == 32'd0) begin
              first_err_adr <= wb_adr;
              first_err_data <= wb_err ? '0 : wb_dat_r;
            end
            if (state == S_WR_WAIT) begin
              lfsr <= last ? LFSR_SEED : lfsr_next;
              state <= last ? S_RD_REQ : S_WR_REQ;
            end else begin
              lfsr <= lfsr_next;
              state <= stop ? S_DONE : S_RD_REQ;
              if (stop) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= err_next == 32'd0;
                fail <= err_next != 32'd0;
              end
            end
          end else if (tmo_hit) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timeout <= 1'b1;
            fail <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_dram_pattern_tester.sv
// tb_wb_dram_pattern_tester: directed runs against an ideal Wishbone memory, checked by a pattern-level model.
module tb_wb_dram_pattern_tester;
  localparam int DW = 256, AW = 25, NW = 4, TO = 16;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, start = 1'b0, init_done = 1'b1, init_error = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [AW-1:0] wb_adr, first_err_adr;
  logic [DW-1:0] wb_dat_w, first_err_data;
  logic [DW-1:0] wb_dat_r = '0;
  logic [DW/8-1:0] wb_sel;
  logic wb_cyc, wb_stb, wb_we, busy, done, pass, fail, timeout;
  logic wb_ack = 1'b0, wb_err = 1'b0;
  logic [31:0] err_count;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] wlog [8];
  logic [DW-1:0] wsave [8];
  int wn = 0, cyc_hi = 0;
  int no_ack = 0, err_adr = -1, flip_adr = -1;
  logic exp_we [8];
  logic [AW-1:0] exp_adr [8];
  logic [DW-1:0] exp_dat [8];
  int n_exp = 0, k = 0;
  logic [DW-1:0] a5, e2, tmp;

  wb_dram_pattern_tester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(0), .NUM_WORDS(NW),
    .TIMEOUT_CYCLES(TO), .LFSR_SEED(SEED), .STOP_ON_ERR(1'b0)
  ) dut (
    .user_clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .init_done(init_done), .init_error(init_error),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack), .wb_err(wb_err),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .first_err_adr(first_err_adr), .first_err_data(first_err_data)
  );

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pattern for word i straight from the definition: step the LFSR i times from the seed.
  function automatic logic [DW-1:0] model_pat(input int m, input int i);
    logic [31:0] s;
    logic [DW-1:0] r;
    s = SEED;
    r = '0;
    for (int n = 0; n < i; n++) s = s[0] ? (s >> 1) ^ 32'h8020_0003 : s >> 1;
    for (int l = 0; l < DW / 32; l++)
      r[l*32 +: 32] = m == 0 ? 32'hA5A5_A5A5 : m == 1 ? 32'(i) : m == 2 ? ~32'(i) : s ^ 32'(l);
    return r;
  endfunction

  task automatic plan(input int m, input int n);
    for (int t = 0; t < 2 * NW; t++) begin
      exp_we[t] = t < NW;
      exp_adr[t] = AW'(t % NW);
      exp_dat[t] = model_pat(m, t % NW);
    end
    n_exp = n;
  endtask

  task automatic run(input logic [1:0] m);
    mode = m;
    wn = 0;
    cyc_hi = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_b("busy_after_start", busy, 1'b1);
    chk_b("done_cleared", done, 1'b0);
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (wb_cyc) cyc_hi++;
    end
    chk_b("done", done, 1'b1);
    chk_b("busy_at_done", busy, 1'b0);
  endtask

  task automatic result(input logic p, input logic t, input int ec, input int fa, input logic [DW-1:0] fd);
    chk_b("pass", pass, p);
    chk_b("fail", fail, !p);
    chk_b("timeout", timeout, t);
    chk_w("err_count", err_count, 32'(ec));
    chk_w("first_err_adr", 32'(first_err_adr), 32'(fa));
    chk_d("first_err_data", first_err_data, fd);
  endtask

  // Ideal memory slave: 3-cycle ack latency, optional no-ack, error and read-corruption injection.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (wb_ack || wb_err) begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        cnt = 0;
      end else if (wb_cyc && wb_stb) begin
        cnt++;
        if (cnt == 3 && no_ack == 0) begin
          if (wb_we && int'(wb_adr) == err_adr) wb_err = 1'b1;
          else begin
            wb_ack = 1'b1;
            if (wb_we) begin
              mem[wb_adr[3:0]] = wb_dat_w;
              if (wn < 8) wlog[wn] = wb_dat_w;
              wn++;
            end else wb_dat_r = mem[wb_adr[3:0]] ^ (int'(wb_adr) == flip_adr ? DW'(1) : DW'(0));
          end
        end
      end else cnt = 0;
    end
  end

  // Every bus cycle must match the planned transaction sequence.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n || start) k = 0;
    else if (wb_cyc) begin
      if (k >= n_exp) chk_b("extra_cyc", wb_cyc, 1'b0);
      else begin
        chk_b("stb", wb_stb, 1'b1);
        chk_b("we", wb_we, exp_we[k]);
        chk_w("adr", 32'(wb_adr), 32'(exp_adr[k]));
        if (exp_we[k]) chk_d("dat_w", wb_dat_w, exp_dat[k]);
      end
      if (wb_ack || wb_err) k++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a5 = {8{32'hA5A5_A5A5}};
    e2 = {{7{32'h2}}, 32'h3};
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_b("rst_cyc", wb_cyc, 1'b0);
    chk_b("rst_stb", wb_stb, 1'b0);
    chk_b("rst_we", wb_we, 1'b0);
    chk_w("rst_sel", wb_sel, 32'hFFFF_FFFF);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_pass", pass, 1'b0);
    chk_b("rst_fail", fail, 1'b0);
    chk_b("rst_timeout", timeout, 1'b0);
    chk_w("rst_err_count", err_count, 32'h0);
    chk_w("rst_adr", 32'(wb_adr), 32'h0);
    chk_d("rst_dat_w", wb_dat_w, '0);
    chk_d("rst_first_err_data", first_err_data, '0);
    rst_n = 1'b1;
    // Fixed pattern, ideal memory.
    tmp = model_pat(0, 3);
    chk_d("model_fixed", tmp, a5);
    plan(0, 8);
    run(2'd0);
    result(1'b1, 1'b0, 0, 0, '0);
    chk_w("t1_writes", 32'(wn), 32'd4);
    chk_w("t1_cyc_cycles", 32'(cyc_hi), 32'd24);
    for (int i = 0; i < NW; i++) chk_d("t1_wdata", wlog[i], a5);
    // Address pattern with bit 0 of word 2 corrupted on read.
    flip_adr = 2;
    plan(1, 8);
    run(2'd1);
    result(1'b0, 1'b0, 1, 2, e2);
    chk_w("t2_lane0", first_err_data[31:0], 32'h3);
    flip_adr = -1;
    // LFSR pattern run twice must repeat.
    tmp = model_pat(3, 1);
    chk_w("model_lfsr1", tmp[31:0], 32'hD650_91A1);
    plan(3, 8);
    run(2'd3);
    result(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < NW; i++) wsave[i] = wlog[i];
    run(2'd3);
    result(1'b1, 1'b0, 0, 0, '0);
    for (int i = 0; i < NW; i++) chk_d("t3_repeat", wlog[i], wsave[i]);
    tmp = wlog[0];
    chk_w("t3_w0_lane1", tmp[63:32], 32'hACE1_2344);
    tmp = wlog[1];
    chk_w("t3_w1_lane0", tmp[31:0], 32'hD650_91A1);
    // Slave never acks: timeout.
    no_ack = 1;
    plan(0, 1);
    run(2'd0);
    result(1'b0, 1'b1, 0, 0, '0);
    chk_w("t4_cyc_cycles", 32'(cyc_hi), 32'(TO));
    no_ack = 0;
    // Calibration failure.
    init_error = 1'b1;
    plan(0, 0);
    run(2'd0);
    result(1'b0, 1'b0, 0, 0, '0);
    chk_w("t5_no_bus", 32'(cyc_hi), 32'd0);
    init_error = 1'b0;
    // wb_err on write 1.
    err_adr = 1;
    mem[1] = a5;
    plan(0, 8);
    run(2'd0);
    result(1'b0, 1'b0, 1, 1, '0);
    err_adr = -1;
    // Reset during the read phase, then a clean run.
    plan(0, 8);
    mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && !(wb_cyc && !wb_we); c++) @(negedge clk);
    chk_b("t6_reached_read", wb_cyc & !wb_we, 1'b1);
    rst_n = 1'b0;
    n_exp = 0;
    @(negedge clk);
    chk_b("t6_cyc", wb_cyc, 1'b0);
    chk_b("t6_stb", wb_stb, 1'b0);
    chk_b("t6_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc_hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_cyc) cyc_hi++;
    end
    chk_w("t6_idle_after_reset", 32'(cyc_hi), 32'd0);
    plan(2, 8);
    run(2'd2);
    result(1'b1, 1'b0, 0, 0, '0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
